// File: rtl/uart_fifo_tx.sv
// UART transmitter that pulls bytes from an upstream small FIFO.
// 8N1 framing, LSB first, with one pop pulse per launched frame.
module uart_fifo_tx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Tx_Enable,
    input  logic [7:0] i_Byte,
    input  logic [2:0] i_Free_Space,
    output logic       o_Shift_Now,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Active,
    output logic       o_Tx_Done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_nxt;
    logic [7:0]       shift;
    logic [7:0]       shift_nxt;
    logic             serial;
    logic             serial_nxt;
    logic             active;
    logic             active_nxt;
    logic             done;
    logic             done_nxt;
    logic             pop;
    logic             pop_nxt;
    logic             last_tick;
    logic             fifo_ready;
    logic             launch;

    // Free-space counts at or above the depth (including bogus ones) mean empty.
    assign fifo_ready = 32'(i_Free_Space) < 32'(FIFO_DEPTH);
    assign launch     = i_Tx_Enable && fifo_ready;
    assign last_tick  = (count == LAST);

    // Next-state and next-output logic; every register has a hold default.
    always_comb begin
        state_nxt  = state;
        count_nxt  = count + CNT_W'(1);
        bit_nxt    = bit_idx;
        shift_nxt  = shift;
        serial_nxt = serial;
        active_nxt = active;
        done_nxt   = 1'b0;
        pop_nxt    = 1'b0;
        unique case (state)
            IDLE: begin
                count_nxt  = '0;
                serial_nxt = 1'b1;
                active_nxt = 1'b0;
                if (launch) begin
                    state_nxt  = START;
                    shift_nxt  = i_Byte;
                    bit_nxt    = 3'd0;
                    serial_nxt = 1'b0;
                    active_nxt = 1'b1;
                    pop_nxt    = 1'b1;
                end
            end
            START: begin
                if (last_tick) begin
                    state_nxt  = DATA;
                    count_nxt  = '0;
                    bit_nxt    = 3'd0;
                    serial_nxt = shift[0];
                end
            end
            DATA: begin
                if (last_tick) begin
                    count_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        state_nxt  = STOP;
                        serial_nxt = 1'b1;
                    end else begin
                        bit_nxt    = bit_idx + 3'd1;
                        shift_nxt  = {1'b0, shift[7:1]};
                        serial_nxt = shift[1];
                    end
                end
            end
            STOP: begin
                serial_nxt = 1'b1;
                if (last_tick) begin
                    state_nxt  = IDLE;
                    count_nxt  = '0;
                    active_nxt = 1'b0;
                    done_nxt   = 1'b1;
                end
            end
            default: begin
                state_nxt  = IDLE;
                count_nxt  = '0;
                serial_nxt = 1'b1;
                active_nxt = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops any in-flight byte.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state   <= IDLE;
            count   <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'd0;
            serial  <= 1'b1;
            active  <= 1'b0;
            done    <= 1'b0;
            pop     <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            bit_idx <= bit_nxt;
            shift   <= shift_nxt;
            serial  <= serial_nxt;
            active  <= active_nxt;
            done    <= done_nxt;
            pop     <= pop_nxt;
        end
    end

    assign o_Shift_Now = pop;
    assign o_Tx_Serial = serial;
    assign o_Tx_Active = active;
    assign o_Tx_Done   = done;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Directed bench for uart_fifo_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Observed bundle is {serial, active, shift_now, done}.
module tb_uart_fifo_tx;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] byte_in;
    logic [2:0] free;
    logic       shift_now;
    logic       serial;
    logic       active;
    logic       done;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    uart_fifo_tx #(
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH  (4)
    ) dut (
        .i_Clk       (clk),
        .i_Rst       (rst),
        .i_Tx_Enable (en),
        .i_Byte      (byte_in),
        .i_Free_Space(free),
        .o_Shift_Now (shift_now),
        .o_Tx_Serial (serial),
        .o_Tx_Active (active),
        .o_Tx_Done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pop pulses are counted on the rising edge, away from the sampling edge.
    always @(posedge clk) begin
        if (shift_now === 1'b1) pulses++;
    end

    typedef struct {
        logic [7:0] data;
        logic [2:0] fs;
        logic       enable;
        logic       launch;
        logic [9:0] line;
        string      nm;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [3:0] obs();
        return {serial, active, shift_now, done};
    endfunction

    task automatic check(input string nm, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%b expected=%b", nm, got, exp);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", nm, got, exp);
        end
    endtask

    // Entered on the sample just after the launch edge (k=0); ends on k=40.
    task automatic watch(input logic [9:0] line, input logic [7:0] nb,
                         input logic [2:0] nf, input int drop_k, input string nm);
        logic [3:0] exp;
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 40) exp = {line[k/4], 1'b1, (k == 0), 1'b0};
            else        exp = 4'b1001;
            check($sformatf("%s k=%0d", nm, k), obs(), exp);
            if (k == 0) begin
                byte_in = nb;
                free    = nf;
            end
            if (k == drop_k) en = 1'b0;
        end
    endtask

    task automatic idle_for(input int n, input string nm);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check($sformatf("%s k=%0d", nm, k), obs(), 4'b1000);
        end
    endtask

    int snap;

    initial begin
        vecs[0] = '{8'h2A, 3'd3, 1'b1, 1'b1, 10'b1001010100, "byte2A"};
        vecs[1] = '{8'hD5, 3'd0, 1'b1, 1'b1, 10'b1110101010, "byteD5"};
        vecs[2] = '{8'h00, 3'd1, 1'b1, 1'b1, 10'b1000000000, "byte00"};
        vecs[3] = '{8'hFF, 3'd3, 1'b1, 1'b1, 10'b1111111110, "byteFF"};
        vecs[4] = '{8'h81, 3'd2, 1'b1, 1'b1, 10'b1100000010, "byte81"};
        vecs[5] = '{8'h5A, 3'd7, 1'b1, 1'b0, 10'b1111111111, "free7"};
        vecs[6] = '{8'h5A, 3'd2, 1'b0, 1'b0, 10'b1111111111, "en_low"};

        rst     = 1'b0;
        en      = 1'b0;
        byte_in = 8'h00;
        free    = 3'd4;
        #1 rst = 1'b1;
        #1 check("reset_async", obs(), 4'b1000);
        en      = 1'b1;
        free    = 3'd3;
        byte_in = 8'hA5;
        @(negedge clk);
        check("reset_hold0", obs(), 4'b1000);
        @(negedge clk);
        check("reset_hold1", obs(), 4'b1000);
        rst  = 1'b0;
        free = 3'd4;

        idle_for(100, "idle_empty");

        for (int i = 0; i < 7; i++) begin
            byte_in = vecs[i].data;
            free    = vecs[i].fs;
            en      = vecs[i].enable;
            snap    = pulses;
            @(negedge clk);
            if (vecs[i].launch) begin
                watch(vecs[i].line, 8'h3C, 3'd4, -1, vecs[i].nm);
                @(negedge clk);
                check($sformatf("%s k=41", vecs[i].nm), obs(), 4'b1000);
                check_int($sformatf("%s pops", vecs[i].nm), pulses - snap, 1);
            end else begin
                check($sformatf("%s k=0", vecs[i].nm), obs(), 4'b1000);
                idle_for(41, vecs[i].nm);
                check_int($sformatf("%s pops", vecs[i].nm), pulses - snap, 0);
            end
            free = 3'd4;
            en   = 1'b1;
            @(negedge clk);
        end

        // Back-to-back: second launch lands exactly 41 cycles after the first.
        byte_in = 8'h2A;
        free    = 3'd2;
        en      = 1'b1;
        snap    = pulses;
        @(negedge clk);
        watch(10'b1001010100, 8'hD5, 3'd3, -1, "b2b_first");
        @(negedge clk);
        watch(10'b1110101010, 8'h00, 3'd4, -1, "b2b_second");
        @(negedge clk);
        check("b2b_idle", obs(), 4'b1000);
        check_int("b2b_pops", pulses - snap, 2);

        // Enable dropped during data bit 3; FIFO stays non-empty meanwhile.
        byte_in = 8'h81;
        free    = 3'd2;
        en      = 1'b1;
        @(negedge clk);
        watch(10'b1100000010, 8'h81, 3'd2, 17, "gate_frame");
        snap = pulses;
        idle_for(12, "gate_hold");
        check_int("gate_no_pop", pulses - snap, 0);
        en = 1'b1;
        @(negedge clk);
        watch(10'b1100000010, 8'h00, 3'd4, -1, "gate_relaunch");
        @(negedge clk);
        check("gate_idle", obs(), 4'b1000);

        // Reset in data bit 5, then the next FIFO byte goes out whole.
        byte_in = 8'h2A;
        free    = 3'd2;
        en      = 1'b1;
        @(negedge clk);
        check("rstmid k=0", obs(), 4'b0110);
        byte_in = 8'hD5;
        for (int k = 1; k <= 25; k++) @(negedge clk);
        check("rstmid k=25", obs(), {1'b1, 1'b1, 1'b0, 1'b0});
        rst = 1'b1;
        #1 check("rstmid_async", obs(), 4'b1000);
        @(negedge clk);
        check("rstmid_hold", obs(), 4'b1000);
        snap = pulses;
        rst  = 1'b0;
        @(negedge clk);
        watch(10'b1110101010, 8'h00, 3'd4, -1, "rstmid_next");
        @(negedge clk);
        check("rstmid_idle", obs(), 4'b1000);
        check_int("rstmid_pops", pulses - snap, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
